// File: rtl/regfile_scoreboard.sv
// Register file with write-first bypass and a per-register outstanding-write scoreboard.
// Register 0 reads as zero and never becomes pending. The read ports are registered or combinational, chosen by READ_SYNC.
module regfile_scoreboard #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int READ_SYNC = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(NREG)-1:0]  rs1_addr,
    input  logic [$clog2(NREG)-1:0]  rs2_addr,
    output logic [XLEN-1:0]          rd1,
    output logic [XLEN-1:0]          rd2,
    input  logic                     we,
    input  logic [$clog2(NREG)-1:0]  wa,
    input  logic [XLEN-1:0]          wd,
    input  logic                     issue_valid,
    input  logic [$clog2(NREG)-1:0]  issue_rd,
    output logic                     hazard,
    output logic [NREG-1:0]          pending,
    output logic [$clog2(NREG):0]    pending_cnt
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_nxt;
    logic [AW:0]     cnt_q;
    logic [AW:0]     cnt_nxt;
    logic [XLEN-1:0] eff1;
    logic [XLEN-1:0] eff2;
    logic            issue_ok;
    logic            cnt_inc;
    logic            cnt_dec;

    function automatic logic [XLEN-1:0] bypass_read(
        input logic [AW-1:0]   ra,
        input logic [XLEN-1:0] stored,
        input logic            wr_en,
        input logic [AW-1:0]   wr_addr,
        input logic [XLEN-1:0] wr_data
    );
        if (ra == '0)
            return '0;
        if (wr_en && (wr_addr == ra))
            return wr_data;
        return stored;
    endfunction

    // A same-cycle write to the read register resolves the hazard through the bypass.
    function automatic logic port_hazard(
        input logic          [AW-1:0] ra,
        input logic                   pend_bit,
        input logic                   wr_en,
        input logic          [AW-1:0] wr_addr
    );
        return (ra != '0) && pend_bit && !(wr_en && (wr_addr == ra));
    endfunction

    assign eff1 = bypass_read(rs1_addr, mem[rs1_addr], we, wa, wd);
    assign eff2 = bypass_read(rs2_addr, mem[rs2_addr], we, wa, wd);

    assign hazard = port_hazard(rs1_addr, pend_q[rs1_addr], we, wa) |
                    port_hazard(rs2_addr, pend_q[rs2_addr], we, wa);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                mem[i] <= '0;
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    assign issue_ok = issue_valid && (issue_rd != '0);

    // Issue is applied after the write clear so a newer producer keeps the register pending.
    always_comb begin
        pend_nxt = pend_q;
        if (we)
            pend_nxt[wa] = 1'b0;
        if (issue_ok)
            pend_nxt[issue_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    assign cnt_inc = issue_ok && !pend_q[issue_rd];
    assign cnt_dec = we && pend_q[wa] && !(issue_ok && (issue_rd == wa));
    assign cnt_nxt = cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    assign pending     = pend_q;
    assign pending_cnt = cnt_q;

    // Read stage: optional register between the effective read value and the ports.
    if (READ_SYNC != 0) begin : g_sync
        logic [XLEN-1:0] rd1_p1;
        logic [XLEN-1:0] rd2_p1;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd1_p1 <= '0;
                rd2_p1 <= '0;
            end else begin
                rd1_p1 <= eff1;
                rd2_p1 <= eff2;
            end
        end

        assign rd1 = rd1_p1;
        assign rd2 = rd2_p1;
    end else begin : g_comb
        assign rd1 = eff1;
        assign rd2 = eff2;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard (READ_SYNC=1): stimulus pushes expectations into a queue, and a monitor pops and compares them.
module tb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    localparam int K_HAZ  = 0;
    localparam int K_RD1  = 1;
    localparam int K_RD2  = 2;
    localparam int K_PEND = 3;
    localparam int K_CNT  = 4;

    typedef struct {
        int          due;
        int          kind;
        logic [63:0] val;
        string       name;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [AW-1:0]   rs1_addr = '0;
    logic [AW-1:0]   rs2_addr = '0;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            we = 1'b0;
    logic [AW-1:0]   wa = '0;
    logic [XLEN-1:0] wd = '0;
    logic            issue_valid = 1'b0;
    logic [AW-1:0]   issue_rd = '0;
    logic            hazard;
    logic [NREG-1:0] pending;
    logic [AW:0]     pending_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    exp_t q[$];

    // Reference state, in architectural terms.
    logic [XLEN-1:0] mem_m [NREG];
    logic [NREG-1:0] pend_m;

    regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .READ_SYNC(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd1(rd1), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .hazard(hazard), .pending(pending), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] dut_out(input int kind);
        case (kind)
            K_HAZ:   return {63'd0, hazard};
            K_RD1:   return {32'd0, rd1};
            K_RD2:   return {32'd0, rd2};
            K_PEND:  return {32'd0, pending};
            default: return {58'd0, pending_cnt};
        endcase
    endfunction

    // Monitor: compare everything due by this cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            while (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                e = q.pop_front();
                check(e.name, dut_out(e.kind), e.val);
            end
        end
    end

    function automatic logic [XLEN-1:0] model_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (we && wa == a) return wd;
        return mem_m[a];
    endfunction

    function automatic logic model_haz(input logic [AW-1:0] a);
        return (a != 0) && pend_m[a] && !(we && wa == a);
    endfunction

    task automatic push(input int due, input int kind, input logic [63:0] val, input string name);
        exp_t e;
        e.due = due; e.kind = kind; e.val = val; e.name = name;
        q.push_back(e);
    endtask

    task automatic step(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic w, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                        input logic iv, input logic [AW-1:0] ir, input string tag);
        @(posedge clk);
        #1;
        rs1_addr = r1; rs2_addr = r2;
        we = w; wa = a; wd = d;
        issue_valid = iv; issue_rd = ir;
        push(cyc,     K_HAZ, {63'd0, model_haz(r1) | model_haz(r2)}, {tag, ".hazard"});
        push(cyc + 1, K_RD1, {32'd0, model_read(r1)}, {tag, ".rd1"});
        push(cyc + 1, K_RD2, {32'd0, model_read(r2)}, {tag, ".rd2"});
        if (w) begin
            if (a != 0) mem_m[a] = d;
            pend_m[a] = 1'b0;
        end
        if (iv && ir != 0) pend_m[ir] = 1'b1;
        push(cyc + 1, K_PEND, {32'd0, pend_m}, {tag, ".pending"});
        push(cyc + 1, K_CNT, 64'($countones(pend_m)), {tag, ".pending_cnt"});
    endtask

    task automatic idle(input string tag);
        step('0, '0, 1'b0, '0, '0, 1'b0, '0, tag);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREG; i++) mem_m[i] = '0;
        pend_m = '0;
    endtask

    // Reset pulsed between edges and held across one edge with write/issue requests that must be ignored.
    task automatic mid_reset();
        @(posedge clk);
        #1;
        we = 1'b0; issue_valid = 1'b0;
        @(negedge clk);
        #1;
        rs1_addr = 5'd1; rs2_addr = 5'd2;
        rst_n = 1'b0;
        we = 1'b1; wa = 5'd5; wd = 32'hCAFEF00D;
        issue_valid = 1'b1; issue_rd = 5'd6;
        #1;
        check("midrst.pending", {32'd0, pending}, 64'd0);
        check("midrst.cnt", {58'd0, pending_cnt}, 64'd0);
        check("midrst.rd1", {32'd0, rd1}, 64'd0);
        check("midrst.rd2", {32'd0, rd2}, 64'd0);
        clear_model();
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        we = 1'b0; issue_valid = 1'b0;
    endtask

    initial begin
        clear_model();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset.pending", {32'd0, pending}, 64'd0);
        check("reset.cnt", {58'd0, pending_cnt}, 64'd0);
        check("reset.rd1", {32'd0, rd1}, 64'd0);
        rst_n = 1'b1;

        // Reset-read of r5/r31.
        step(5'd5, 5'd31, 1'b0, '0, '0, 1'b0, '0, "rstread");
        idle("rstread2");
        // Write then read, and r0 ignores writes.
        step('0, '0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0, "wr_r3");
        step(5'd3, '0, 1'b0, '0, '0, 1'b0, '0, "rd_r3");
        step('0, '0, 1'b1, 5'd0, 32'h00001234, 1'b0, '0, "wr_r0");
        step(5'd0, 5'd3, 1'b0, '0, '0, 1'b0, '0, "rd_r0");
        // Write-first bypass on port 2.
        step('0, 5'd7, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, '0, "bypass");
        idle("bypass2");
        // Issue r4, hazard, then write resolves it.
        step('0, '0, 1'b0, '0, '0, 1'b1, 5'd4, "iss_r4");
        step(5'd4, '0, 1'b0, '0, '0, 1'b0, '0, "haz_r4");
        step(5'd4, '0, 1'b1, 5'd4, 32'h44444444, 1'b0, '0, "res_r4");
        step(5'd4, 5'd4, 1'b0, '0, '0, 1'b0, '0, "after_r4");
        // Simultaneous issue/write.
        step('0, '0, 1'b0, '0, '0, 1'b1, 5'd11, "iss_r11");
        step(5'd9, '0, 1'b1, 5'd9, 32'h99999999, 1'b1, 5'd9, "iss_wr_r9");
        step(5'd9, 5'd11, 1'b1, 5'd11, 32'hBBBBBBBB, 1'b1, 5'd10, "iss10_wr11");
        step(5'd10, 5'd11, 1'b0, '0, '0, 1'b1, 5'd10, "reissue_r10");
        step('0, '0, 1'b0, '0, '0, 1'b1, 5'd0, "issue_r0");
        idle("simul_end");
        // Reset in the middle of activity.
        step('0, '0, 1'b1, 5'd1, 32'h11111111, 1'b1, 5'd1, "iss_r1");
        step('0, '0, 1'b0, '0, '0, 1'b1, 5'd2, "iss_r2");
        step('0, '0, 1'b0, '0, '0, 1'b1, 5'd3, "iss_r3");
        idle("pre_rst");
        mid_reset();
        step(5'd1, 5'd5, 1'b0, '0, '0, 1'b0, '0, "post_rst");
        step(5'd6, 5'd3, 1'b0, '0, '0, 1'b0, '0, "post_rst2");

        // Randomized traffic over a small address window to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            step(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), "rand");
        end
        for (int i = 0; i < NREG; i++)
            step(AW'(i), AW'(NREG - 1 - i), 1'b1, AW'(i), $urandom, 1'b0, '0, "sweep");
        idle("drain");
        repeat (3) @(negedge clk);
        #1;
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
